// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with write priority, scoreboard and post-reset clear (optional REGFILE_BYPASS_EN)
module regfile_mp #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int NRD = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ready,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*DW-1:0] rd,
  output logic [NRD-1:0]    rd_busy,
  input  logic              we0,
  input  logic [AW-1:0]     wa0,
  input  logic [DW-1:0]     wd0,
  input  logic              we1,
  input  logic [AW-1:0]     wa1,
  input  logic [DW-1:0]     wd1,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_addr
);

  localparam int NREG = 2 ** AW;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  localparam logic [AW-1:0] LAST_REG = {AW{1'b1}};

  logic [0:0]    state;
  logic [AW-1:0] clr_cnt;
  logic [DW-1:0] mem [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  logic wr0_ok;
  logic wr1_ok;
  logic alloc_ok;

  logic [AW-1:0] rd_addr [NRD];
  logic [DW-1:0] rd_nxt  [NRD];
  logic          bz_nxt  [NRD];

  // Writes and allocations only take effect once the clear has finished; r0 is never a target.
  assign wr0_ok   = (state == ST_READY) && we0 && (wa0 != '0);
  assign wr1_ok   = (state == ST_READY) && we1 && (wa1 != '0);
  assign alloc_ok = (state == ST_READY) && alloc_en && (alloc_addr != '0);

  assign ready = (state == ST_READY);

  genvar g;
  generate
    for (g = 0; g < NRD; g++) begin : g_addr
      assign rd_addr[g] = ra[g*AW +: AW];
    end
  endgenerate

  // Sequencer: CLEAR walks the counter from 1 up to the last register, then READY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= {{(AW-1){1'b0}}, 1'b1};
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == LAST_REG) begin
        state <= ST_READY;
      end
    end
  end

  // Storage: clear writes zeros; in READY port 1 is applied last so it wins an address clash.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == ST_CLEAR) begin
        mem[clr_cnt] <= '0;
      end else begin
        if (wr0_ok) begin
          mem[wa0] <= wd0;
        end
        if (wr1_ok) begin
          mem[wa1] <= wd1;
        end
      end
    end
  end

  // Scoreboard next state: writes retire pending bits, an allocation in the same cycle overrides.
  always_comb begin
    busy_nxt = busy;
    if (wr0_ok) begin
      busy_nxt[wa0] = 1'b0;
    end
    if (wr1_ok) begin
      busy_nxt[wa1] = 1'b0;
    end
    if (alloc_ok) begin
      busy_nxt[alloc_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Read-port next values: zero during CLEAR and for r0, otherwise the pre-edge contents.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_nxt[i] = '0;
      bz_nxt[i] = 1'b0;
      if ((state == ST_READY) && (rd_addr[i] != '0)) begin
`ifdef REGFILE_BYPASS_EN
        if (wr1_ok && (wa1 == rd_addr[i])) begin
          rd_nxt[i] = wd1;
          bz_nxt[i] = alloc_ok && (alloc_addr == rd_addr[i]);
        end else if (wr0_ok && (wa0 == rd_addr[i])) begin
          rd_nxt[i] = wd0;
          bz_nxt[i] = alloc_ok && (alloc_addr == rd_addr[i]);
        end else begin
          rd_nxt[i] = mem[rd_addr[i]];
          bz_nxt[i] = busy[rd_addr[i]];
        end
`else
        rd_nxt[i] = mem[rd_addr[i]];
        bz_nxt[i] = busy[rd_addr[i]];
`endif
      end
    end
  end

  // Registered read outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd      <= '0;
      rd_busy <= '0;
    end else begin
      for (int i = 0; i < NRD; i++) begin
        rd[i*DW +: DW] <= rd_nxt[i];
        rd_busy[i]     <= bz_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp
module tb_regfile_mp;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;

  logic              clk;
  logic              rst_n;
  logic              ready;
  logic [NRD*AW-1:0] ra;
  logic [NRD*DW-1:0] rd;
  logic [NRD-1:0]    rd_busy;
  logic              we0;
  logic [AW-1:0]     wa0;
  logic [DW-1:0]     wd0;
  logic              we1;
  logic [AW-1:0]     wa1;
  logic [DW-1:0]     wd1;
  logic              alloc_en;
  logic [AW-1:0]     alloc_addr;

  int tests;
  int failed;
  int n;

  regfile_mp #(.DW(DW), .AW(AW), .NRD(NRD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ready      (ready),
    .ra         (ra),
    .rd         (rd),
    .rd_busy    (rd_busy),
    .we0        (we0),
    .wa0        (wa0),
    .wd0        (wd0),
    .we1        (we1),
    .wa1        (wa1),
    .wd1        (wd1),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    alloc_en = 1'b0; alloc_addr = '0;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    ra = {a1, a0};
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst_n  = 1'b0;
    idle();
    set_ra(5'd0, 5'd0);

    // Reset held for three cycles.
    repeat (3) step();
    check("reset_ready", {63'd0, ready}, 64'd0);
    check("reset_rd", rd, 64'd0);
    check("reset_busy", {62'd0, rd_busy}, 64'd0);

    // Release: ready must rise on the 31st edge.
    rst_n = 1'b1;
    n = 0;
    while (!ready && n < 100) begin
      step();
      n++;
      if (n == 10) begin
        check("clear_rd_zero", rd, 64'd0);
      end
    end
    check("clear_len1", n, 64'd31);

    // Write r5 via port 0, read via port 1 next edge.
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
    step();
    idle();
    set_ra(5'd0, 5'd5);
    step();
    check("wr_rd_r5", rd[63:32], 64'h00000000DEADBEEF);

    // Write to r0 is dropped.
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h1234;
    step();
    idle();
    set_ra(5'd0, 5'd0);
    step();
    check("r0_zero", rd[31:0], 64'd0);

    // Clash on r7: port 1 wins; also independent writes on both ports.
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
    step();
    we0 = 1'b1; wa0 = 5'd10; wd0 = 32'h100;
    we1 = 1'b1; wa1 = 5'd11; wd1 = 32'h200;
    set_ra(5'd7, 5'd0);
    step();
    idle();
    check("clash_r7", rd[31:0], 64'h22);
    set_ra(5'd10, 5'd11);
    step();
    check("dual_r10", rd[31:0], 64'h100);
    check("dual_r11", rd[63:32], 64'h200);

    // Same-edge read and write of r3.
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hA;
    step();
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hB;
    set_ra(5'd3, 5'd0);
    step();
    idle();
`ifdef REGFILE_BYPASS_EN
    check("same_edge_r3", rd[31:0], 64'hB);
`else
    check("same_edge_r3", rd[31:0], 64'hA);
`endif
    step();
    check("after_r3", rd[31:0], 64'hB);

    // Scoreboard on r9.
    alloc_en = 1'b1; alloc_addr = 5'd9;
    set_ra(5'd9, 5'd0);
    step();
    idle();
    check("alloc_pre_edge", {62'd0, rd_busy}, 64'd0);
    step();
    check("alloc_busy", {62'd0, rd_busy}, 64'd1);
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h99;
    alloc_en = 1'b1; alloc_addr = 5'd9;
    step();
    idle();
    check("wr_alloc_same", {62'd0, rd_busy}, 64'd1);
    step();
    check("alloc_wins", {62'd0, rd_busy}, 64'd1);
    check("r9_data", rd[31:0], 64'h99);
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h98;
    set_ra(5'd0, 5'd9);
    step();
    idle();
`ifdef REGFILE_BYPASS_EN
    check("wr_clears_pre", {62'd0, rd_busy}, 64'd0);
`else
    check("wr_clears_pre", {62'd0, rd_busy}, 64'd2);
`endif
    step();
    check("wr_clears", {62'd0, rd_busy}, 64'd0);
    check("r9_data2", rd[63:32], 64'h98);

    // Leave r6 busy, then reset and restart the clear part way through.
    alloc_en = 1'b1; alloc_addr = 5'd6;
    step();
    idle();
    rst_n = 1'b0;
    step();
    check("rst2_ready", {63'd0, ready}, 64'd0);
    rst_n = 1'b1;
    set_ra(5'd6, 5'd5);
    repeat (19) step();
    check("midclear_ready", {63'd0, ready}, 64'd0);
    check("midclear_busy", {62'd0, rd_busy}, 64'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    we0 = 1'b1; wa0 = 5'd6; wd0 = 32'h55;
    we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h66;
    alloc_en = 1'b1; alloc_addr = 5'd6;
    n = 0;
    while (!ready && n < 100) begin
      step();
      n++;
    end
    idle();
    check("clear_len2", n, 64'd31);
    step();
    check("clear_wipes_r6", rd[31:0], 64'd0);
    check("clear_wipes_r5", rd[63:32], 64'd0);
    check("clear_no_alloc", {62'd0, rd_busy}, 64'd0);

    // First write after ready is accepted.
    we0 = 1'b1; wa0 = 5'd6; wd0 = 32'h77;
    step();
    idle();
    step();
    check("post_clear_wr", rd[31:0], 64'h77);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
